// File: rtl/ps2_pkg.sv
// Shared PS/2 scancodes, button indices, decoder state encoding and the default key map.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam logic [7:0] KEY_P0_UP    = 8'h1D;
    localparam logic [7:0] KEY_P0_DOWN  = 8'h1B;
    localparam logic [7:0] KEY_P0_LEFT  = 8'h1C;
    localparam logic [7:0] KEY_P0_RIGHT = 8'h23;
    localparam logic [7:0] KEY_P0_FIRE  = 8'h29;
    localparam logic [7:0] KEY_P1_UP    = 8'h43;
    localparam logic [7:0] KEY_P1_DOWN  = 8'h42;
    localparam logic [7:0] KEY_P1_LEFT  = 8'h3B;
    localparam logic [7:0] KEY_P1_RIGHT = 8'h4B;
    localparam logic [7:0] KEY_P1_FIRE  = 8'h5A;

    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;
    localparam int unsigned BTN_FIRE  = 4;
    localparam int unsigned NUM_BTNS  = 5;

    localparam int unsigned KEY_W       = 9;
    localparam int unsigned DEF_PLAYERS = 2;
    localparam int unsigned DEF_MAP_W   = DEF_PLAYERS * NUM_BTNS * KEY_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_t;

    // Entry p*NUM_BTNS+b holds {ext,code} for player p, button b.
    function automatic logic [DEF_MAP_W-1:0] default_keymap();
        logic [DEF_MAP_W-1:0] km;
        km = '0;
        km[(0*NUM_BTNS + BTN_UP   )*KEY_W +: KEY_W] = {1'b0, KEY_P0_UP};
        km[(0*NUM_BTNS + BTN_DOWN )*KEY_W +: KEY_W] = {1'b0, KEY_P0_DOWN};
        km[(0*NUM_BTNS + BTN_LEFT )*KEY_W +: KEY_W] = {1'b0, KEY_P0_LEFT};
        km[(0*NUM_BTNS + BTN_RIGHT)*KEY_W +: KEY_W] = {1'b0, KEY_P0_RIGHT};
        km[(0*NUM_BTNS + BTN_FIRE )*KEY_W +: KEY_W] = {1'b0, KEY_P0_FIRE};
        km[(1*NUM_BTNS + BTN_UP   )*KEY_W +: KEY_W] = {1'b0, KEY_P1_UP};
        km[(1*NUM_BTNS + BTN_DOWN )*KEY_W +: KEY_W] = {1'b0, KEY_P1_DOWN};
        km[(1*NUM_BTNS + BTN_LEFT )*KEY_W +: KEY_W] = {1'b0, KEY_P1_LEFT};
        km[(1*NUM_BTNS + BTN_RIGHT)*KEY_W +: KEY_W] = {1'b0, KEY_P1_RIGHT};
        km[(1*NUM_BTNS + BTN_FIRE )*KEY_W +: KEY_W] = {1'b0, KEY_P1_FIRE};
        return km;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 receiver: synchronises and filters kclk/kdata, deframes 11-bit frames,
// checks start/parity/stop and aborts stalled frames.
module ps2_rx_frame #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kclk,
    input  logic       kdata,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int unsigned FW = $clog2(FILTER_LEN);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC);

    // Index 0 is kclk, index 1 is kdata.
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    filt;
    logic [FW-1:0] fcnt [2];
    logic          kclk_prev;
    logic          fall_c;
    logic [3:0]    bit_cnt;
    logic [9:0]    shreg;
    logic [TW-1:0] idle_cnt;

    // Filtered level only follows the synchronised input after FILTER_LEN agreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= '1;
            sync2   <= '1;
            filt    <= '1;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            sync1 <= {kdata, kclk};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + FW'(1);
                end
            end
        end
    end

    assign fall_c = kclk_prev & ~filt[0];

    // Shift register fills LSB-last, so after bit 9 shreg[0]=start, [8:1]=data, [9]=parity.
    always_ff @(posedge clk) begin
        if (rst) begin
            kclk_prev  <= 1'b1;
            bit_cnt    <= '0;
            shreg      <= '0;
            idle_cnt   <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            kclk_prev  <= filt[0];
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall_c) begin
                idle_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (!shreg[0] && (^shreg[9:1]) && filt[1]) begin
                        byte_valid <= 1'b1;
                        byte_data  <= shreg[8:1];
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    shreg   <= {filt[1], shreg[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    bit_cnt   <= '0;
                    idle_cnt  <= '0;
                    frame_err <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + TW'(1);
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_key_mapper.sv
// PS/2 keyboard front end: decodes make/break/extended sequences and keeps a
// per-player held-button bitmap for the tank controllers.
module ps2_key_mapper
    import ps2_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter logic [NUM_PLAYERS*NUM_BTNS*KEY_W-1:0] KEYMAP = default_keymap()
) (
    input  logic                         clk_50m,
    input  logic                         rst,
    input  logic                         kclk,
    input  logic                         kdata,
    input  logic                         clr_keys,
    output logic [NUM_PLAYERS*NUM_BTNS-1:0] btns,
    output logic                         key_event,
    output logic [8:0]                   key_code,
    output logic                         key_break,
    output logic                         frame_err
);

    localparam int unsigned NUM_KEYS = NUM_PLAYERS * NUM_BTNS;

    logic                byte_valid;
    logic [7:0]          byte_data;
    dec_state_t          state;
    dec_state_t          state_nxt;
    logic                ev_nxt;
    logic [8:0]          code_nxt;
    logic                brk_nxt;
    logic [NUM_KEYS-1:0] btns_nxt;

    ps2_rx_frame #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk       (clk_50m),
        .rst       (rst),
        .kclk      (kclk),
        .kdata     (kdata),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state     <= ST_IDLE;
            btns      <= '0;
            key_event <= 1'b0;
            key_code  <= '0;
            key_break <= 1'b0;
        end else begin
            state     <= state_nxt;
            btns      <= btns_nxt;
            key_event <= ev_nxt;
            if (ev_nxt) begin
                key_code  <= code_nxt;
                key_break <= brk_nxt;
            end
        end
    end

    // Prefix decoder; a receiver error always resynchronises to IDLE.
    always_comb begin
        state_nxt = state;
        ev_nxt    = 1'b0;
        code_nxt  = '0;
        brk_nxt   = 1'b0;
        if (frame_err) begin
            state_nxt = ST_IDLE;
        end else if (byte_valid) begin
            case (state)
                ST_IDLE: begin
                    if (byte_data == PS2_EXT) begin
                        state_nxt = ST_EXT;
                    end else if (byte_data == PS2_BRK) begin
                        state_nxt = ST_BRK;
                    end else begin
                        ev_nxt   = 1'b1;
                        code_nxt = {1'b0, byte_data};
                    end
                end
                ST_EXT: begin
                    if (byte_data == PS2_BRK) begin
                        state_nxt = ST_EXT_BRK;
                    end else if (byte_data != PS2_EXT) begin
                        ev_nxt    = 1'b1;
                        code_nxt  = {1'b1, byte_data};
                        state_nxt = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if (byte_data == PS2_EXT) begin
                        state_nxt = ST_IDLE;
                    end else if (byte_data != PS2_BRK) begin
                        ev_nxt    = 1'b1;
                        code_nxt  = {1'b0, byte_data};
                        brk_nxt   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    state_nxt = ST_IDLE;
                    if (byte_data != PS2_EXT && byte_data != PS2_BRK) begin
                        ev_nxt   = 1'b1;
                        code_nxt = {1'b1, byte_data};
                        brk_nxt  = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Every matching map entry follows the event; clr_keys overrides any make.
    always_comb begin
        btns_nxt = btns;
        if (clr_keys) begin
            btns_nxt = '0;
        end else if (ev_nxt) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (KEYMAP[k*KEY_W +: KEY_W] == code_nxt) begin
                    btns_nxt[k] = ~brk_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_mapper.sv
// Directed bench for ps2_key_mapper: drives a PS/2 device model and checks decoded events and btns.
module tb_ps2_key_mapper;

    localparam int unsigned TO_CYC  = 3000;
    localparam int unsigned HALF_T  = 1000;

    logic       clk_50m = 1'b0;
    logic       rst     = 1'b1;
    logic       kclk    = 1'b1;
    logic       kdata   = 1'b1;
    logic       clr_keys = 1'b0;
    logic [9:0] btns;
    logic       key_event;
    logic [8:0] key_code;
    logic       key_break;
    logic       frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int ev_cnt = 0;
    int err_cnt = 0;
    logic [8:0] last_code = '0;
    logic       last_brk = 1'b0;
    bit         clr_hit;

    ps2_key_mapper #(
        .NUM_PLAYERS(2),
        .FILTER_LEN (8),
        .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk_50m  (clk_50m),
        .rst      (rst),
        .kclk     (kclk),
        .kdata    (kdata),
        .clr_keys (clr_keys),
        .btns     (btns),
        .key_event(key_event),
        .key_code (key_code),
        .key_break(key_break),
        .frame_err(frame_err)
    );

    always #10 clk_50m = ~clk_50m;

    always @(negedge clk_50m) begin
        if (key_event) begin
            ev_cnt    = ev_cnt + 1;
            last_code = key_code;
            last_brk  = key_break;
        end
        if (frame_err) err_cnt = err_cnt + 1;
    end

    // Device model: data changes mid-high phase, optional short kclk glitches on bits 3..6.
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits, input bit glitch);
        logic [10:0] fr;
        fr = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            #(HALF_T/2);
            kdata = fr[i];
            if (glitch && i >= 3 && i <= 6) begin
                #100 kclk = 1'b0;
                #5   kclk = 1'b1;
                #(HALF_T/2 - 105);
            end else begin
                #(HALF_T/2);
            end
            kclk = 1'b0;
            #(HALF_T);
            kclk = 1'b1;
        end
        #(HALF_T/2);
        kdata = 1'b1;
        #(HALF_T*4);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 11, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk_50m);
        rst = 1'b0;
        @(negedge clk_50m);
        n_cmp++; if (btns !== 10'd0) begin n_bad++; $display("FAIL reset_btns: got %b want %b", btns, 10'd0); end
        n_cmp++; if (key_event !== 1'b0) begin n_bad++; $display("FAIL reset_key_event: got %b want 0", key_event); end
        n_cmp++; if (key_code !== 9'h000) begin n_bad++; $display("FAIL reset_key_code: got %h want 000", key_code); end
        n_cmp++; if (key_break !== 1'b0) begin n_bad++; $display("FAIL reset_key_break: got %b want 0", key_break); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    endtask

    task automatic test_make_break();
        int e0;
        e0 = ev_cnt;
        send(8'h1D);
        n_cmp++; if (ev_cnt - e0 !== 1) begin n_bad++; $display("FAIL mb_make_events: got %0d want 1", ev_cnt - e0); end
        n_cmp++; if ({last_brk, last_code} !== {1'b0, 9'h01D}) begin n_bad++; $display("FAIL mb_make_code: got %b/%h want 0/01d", last_brk, last_code); end
        n_cmp++; if (btns !== 10'b00000_00001) begin n_bad++; $display("FAIL mb_make_btns: got %b want 0000000001", btns); end
        send(8'hF0);
        n_cmp++; if (ev_cnt - e0 !== 1) begin n_bad++; $display("FAIL mb_prefix_no_event: got %0d want 1", ev_cnt - e0); end
        send(8'h1D);
        n_cmp++; if (ev_cnt - e0 !== 2) begin n_bad++; $display("FAIL mb_break_events: got %0d want 2", ev_cnt - e0); end
        n_cmp++; if ({last_brk, last_code} !== {1'b1, 9'h01D}) begin n_bad++; $display("FAIL mb_break_code: got %b/%h want 1/01d", last_brk, last_code); end
        n_cmp++; if (btns !== 10'd0) begin n_bad++; $display("FAIL mb_break_btns: got %b want 0", btns); end
    endtask

    task automatic test_multi_hold();
        send(8'h1D);
        send(8'h29);
        send(8'h43);
        n_cmp++; if (btns !== 10'b00001_10001) begin n_bad++; $display("FAIL multi_hold: got %b want 0000110001", btns); end
        send(8'h43);
        n_cmp++; if (btns !== 10'b00001_10001) begin n_bad++; $display("FAIL multi_typematic: got %b want 0000110001", btns); end
        send(8'hF0);
        send(8'h29);
        n_cmp++; if (btns !== 10'b00001_00001) begin n_bad++; $display("FAIL multi_release: got %b want 0000100001", btns); end
        send(8'hF0); send(8'h1D);
        send(8'hF0); send(8'h43);
        n_cmp++; if (btns !== 10'd0) begin n_bad++; $display("FAIL multi_all_released: got %b want 0", btns); end
    endtask

    task automatic test_extended();
        int e0;
        e0 = ev_cnt;
        send(8'hE0); send(8'h75);
        n_cmp++; if (ev_cnt - e0 !== 1) begin n_bad++; $display("FAIL ext_make_events: got %0d want 1", ev_cnt - e0); end
        n_cmp++; if ({last_brk, last_code} !== {1'b0, 9'h175}) begin n_bad++; $display("FAIL ext_make_code: got %b/%h want 0/175", last_brk, last_code); end
        send(8'hE0); send(8'hF0); send(8'h75);
        n_cmp++; if (ev_cnt - e0 !== 2) begin n_bad++; $display("FAIL ext_break_events: got %0d want 2", ev_cnt - e0); end
        n_cmp++; if ({last_brk, last_code} !== {1'b1, 9'h175}) begin n_bad++; $display("FAIL ext_break_code: got %b/%h want 1/175", last_brk, last_code); end
        n_cmp++; if (btns !== 10'd0) begin n_bad++; $display("FAIL ext_btns: got %b want 0", btns); end
    endtask

    task automatic test_parity_err();
        int e0, r0;
        e0 = ev_cnt; r0 = err_cnt;
        send_frame(8'h5A, 1'b1, 11, 1'b0);
        n_cmp++; if (err_cnt - r0 !== 1) begin n_bad++; $display("FAIL par_frame_err: got %0d want 1", err_cnt - r0); end
        n_cmp++; if (ev_cnt - e0 !== 0) begin n_bad++; $display("FAIL par_no_event: got %0d want 0", ev_cnt - e0); end
        n_cmp++; if (btns !== 10'd0) begin n_bad++; $display("FAIL par_btns: got %b want 0", btns); end
        send(8'h5A);
        n_cmp++; if (btns !== 10'b10000_00000) begin n_bad++; $display("FAIL par_recover: got %b want 1000000000", btns); end
        n_cmp++; if (err_cnt - r0 !== 1) begin n_bad++; $display("FAIL par_clean_no_err: got %0d want 1", err_cnt - r0); end
        send(8'hF0); send(8'h5A);
    endtask

    task automatic test_timeout();
        int e0, r0, waited;
        e0 = ev_cnt; r0 = err_cnt;
        send_frame(8'h23, 1'b0, 4, 1'b0);
        waited = 0;
        while (err_cnt == r0 && waited < int'(TO_CYC) + 500) begin
            @(negedge clk_50m);
            waited++;
        end
        n_cmp++; if (err_cnt - r0 !== 1) begin n_bad++; $display("FAIL to_frame_err: got %0d want 1 after %0d cycles", err_cnt - r0, waited); end
        n_cmp++; if (waited < int'(TO_CYC) / 2) begin n_bad++; $display("FAIL to_too_early: got %0d cycles want >= %0d", waited, TO_CYC / 2); end
        send(8'h23);
        n_cmp++; if (btns !== 10'b00000_01000) begin n_bad++; $display("FAIL to_recover_btns: got %b want 0000001000", btns); end
        n_cmp++; if (ev_cnt - e0 !== 1) begin n_bad++; $display("FAIL to_events: got %0d want 1", ev_cnt - e0); end
        send(8'hF0); send(8'h23);
    endtask

    task automatic test_glitch_clr();
        int e0, r0;
        r0 = err_cnt;
        send_frame(8'h1C, 1'b0, 11, 1'b1);
        n_cmp++; if (btns !== 10'b00000_00100) begin n_bad++; $display("FAIL glitch_btns: got %b want 0000000100", btns); end
        n_cmp++; if (err_cnt - r0 !== 0) begin n_bad++; $display("FAIL glitch_no_err: got %0d want 0", err_cnt - r0); end
        e0 = ev_cnt;
        clr_hit = 1'b0;
        fork
            send(8'h1D);
            begin
                for (int c = 0; c < 20000 && !clr_hit; c++) begin
                    @(negedge clk_50m);
                    if (dut.u_rx.byte_valid === 1'b1) begin
                        clr_keys = 1'b1;
                        clr_hit  = 1'b1;
                        @(negedge clk_50m);
                        clr_keys = 1'b0;
                    end
                end
            end
        join
        n_cmp++; if (clr_hit !== 1'b1) begin n_bad++; $display("FAIL clr_sync: got %b want 1", clr_hit); end
        n_cmp++; if (btns !== 10'd0) begin n_bad++; $display("FAIL clr_wins: got %b want 0", btns); end
        n_cmp++; if (ev_cnt - e0 !== 1) begin n_bad++; $display("FAIL clr_event: got %0d want 1", ev_cnt - e0); end
        send(8'h1D);
        n_cmp++; if (btns !== 10'b00000_00001) begin n_bad++; $display("FAIL rst_pre_btns: got %b want 0000000001", btns); end
        send_frame(8'h5A, 1'b0, 5, 1'b0);
        @(negedge clk_50m);
        rst = 1'b1;
        repeat (3) @(negedge clk_50m);
        rst = 1'b0;
        @(negedge clk_50m);
        n_cmp++; if (btns !== 10'd0) begin n_bad++; $display("FAIL rst_mid_btns: got %b want 0", btns); end
        n_cmp++; if (key_code !== 9'h000) begin n_bad++; $display("FAIL rst_mid_code: got %h want 000", key_code); end
        send(8'h5A);
        n_cmp++; if (btns !== 10'b10000_00000) begin n_bad++; $display("FAIL rst_after_frame: got %b want 1000000000", btns); end
        n_cmp++; if (err_cnt - r0 !== 0) begin n_bad++; $display("FAIL rst_no_err: got %0d want 0", err_cnt - r0); end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_multi_hold();
        test_extended();
        test_parity_err();
        test_timeout();
        test_glitch_clr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
